// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encodings and serial line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: tick pulses on the last clock of each bit; held cleared while en is low.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset || !en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: valid/ready byte in, framed serial line out with optional parity and 1/2 stop bits.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  uart_state_t          state, state_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [BCW-1:0]       bit_cnt, bit_cnt_next;
  logic                 parity, parity_next;
  logic                 line_next;
  logic                 tick;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .reset(reset),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  // State, datapath and registered line outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      parity   <= 1'b0;
      tx       <= LINE_IDLE;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      bit_cnt  <= bit_cnt_next;
      parity   <= parity_next;
      tx       <= line_next;
      tx_ready <= (state_next == ST_IDLE);
      busy     <= (state_next != ST_IDLE);
    end
  end

  // Next-state, datapath update and line level of the upcoming cycle
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    parity_next  = parity;
    done         = 1'b0;

    unique case (state)
      ST_IDLE: begin
        bit_cnt_next = '0;
        if (tx_valid && tx_ready) begin
          shreg_next  = tx_data;
          parity_next = (PARITY_ODD != 0);
          state_next  = ST_START;
        end
      end
      ST_START: begin
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shreg_next  = {1'b0, shreg[DATA_BITS-1:1]};
          parity_next = parity ^ shreg[0];
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_next = '0;
            state_next   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt + BCW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_next = '0;
            state_next   = ST_IDLE;
            done         = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt + BCW'(1);
          end
        end
      end
      default: begin
        bit_cnt_next = '0;
        state_next   = ST_IDLE;
      end
    endcase

    line_next = LINE_IDLE;
    case (state_next)
      ST_START:  line_next = LINE_START;
      ST_DATA:   line_next = shreg_next[0];
      ST_PARITY: line_next = parity_next;
      ST_STOP:   line_next = LINE_STOP;
      default:   line_next = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: five configurations checked against a bit-list frame model.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] td  [5];
  logic       tv  [5];
  logic       txl [5];
  logic       rdy [5];
  logic       bsy [5];
  logic       dn  [5];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .tx_data(td[0]), .tx_valid(tv[0]), .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]), .done(dn[0]));
  uart_tx_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .tx_data(td[1]), .tx_valid(tv[1]), .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]), .done(dn[1]));
  uart_tx_engine #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .tx_data(td[2]), .tx_valid(tv[2]), .tx_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]), .done(dn[2]));
  uart_tx_engine #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .tx_data(td[3][6:0]), .tx_valid(tv[3]), .tx_ready(rdy[3]), .tx(txl[3]), .busy(bsy[3]), .done(dn[3]));
  uart_tx_engine #(.CLKS_PER_BIT(434), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u4 (
    .clk(clk), .reset(reset), .tx_data(td[4]), .tx_valid(tv[4]), .tx_ready(rdy[4]), .tx(txl[4]), .busy(bsy[4]), .done(dn[4]));

  // Configuration of each instance
  function automatic int cpb(input int i);
    return (i == 4) ? 434 : 4;
  endfunction
  function automatic int nd(input int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int pe(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction
  function automatic int po(input int i);
    return (i == 2) ? 1 : 0;
  endfunction
  function automatic int sb(input int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int nbits(input int i);
    return 1 + nd(i) + pe(i) + sb(i);
  endfunction

  // Frame model: bit b of the serial frame for payload d
  function automatic logic exp_bit(input int i, input logic [7:0] d, input int b);
    int ones = 0;
    for (int j = 0; j < nd(i); j++) ones += int'(d[j]);
    if (b == 0) return 1'b0;
    if (b <= nd(i)) return d[b-1];
    if (pe(i) == 1 && b == nd(i) + 1) return 1'((ones + po(i)) % 2);
    return 1'b1;
  endfunction

  // Observations from the most recent run_frame
  logic obs  [16];
  bit   unst [16];
  int   done_cnt, done_pos, busy_err;
  int   edge_q[$];
  logic rdy_after, tx_after, dn_after;

  task automatic run_frame(input int i, input logic [7:0] d);
    int   c = cpb(i);
    int   f = nbits(i) * c;
    int   w = 0;
    int   b;
    logic prev = 1'b1;
    for (int k = 0; k < 16; k++) begin obs[k] = 1'b0; unst[k] = 1'b0; end
    done_cnt = 0; done_pos = -1; busy_err = 0; edge_q.delete();
    @(negedge clk);
    while (!rdy[i] && w < 50) begin @(negedge clk); w++; end
    td[i] = d; tv[i] = 1'b1;
    @(posedge clk); #1;
    tv[i] = 1'b0; td[i] = ~d;
    for (int k = 0; k < f; k++) begin
      @(negedge clk);
      b = k / c;
      if (k % c == 0) obs[b] = txl[i];
      else if (obs[b] !== txl[i]) unst[b] = 1'b1;
      if (txl[i] !== prev) edge_q.push_back(k);
      prev = txl[i];
      if (dn[i] === 1'b1) begin done_cnt++; done_pos = k; end
      if (bsy[i] !== 1'b1 || rdy[i] !== 1'b0) busy_err++;
      tv[i] = (k == f / 2);
    end
    @(negedge clk);
    rdy_after = rdy[i]; tx_after = txl[i]; dn_after = dn[i];
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (txl[i] !== 1'b1 || rdy[i] !== 1'b1 || bsy[i] !== 1'b0 || dn[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_state u%0d: tx/ready/busy/done = %b%b%b%b, expected 1100", i, txl[i], rdy[i], bsy[i], dn[i]);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_frame_format(input int i, input logic [7:0] d);
    int c = cpb(i);
    int f = nbits(i) * c;
    run_frame(i, d);
    for (int b = 0; b < nbits(i); b++) begin
      tests_run++;
      if (obs[b] !== exp_bit(i, d, b) || unst[b]) begin
        tests_failed++;
        $display("FAIL frame_bit u%0d data=%h bit%0d: got %b (unstable=%0d), expected %b", i, d, b, obs[b], unst[b], exp_bit(i, d, b));
      end
    end
    tests_run++;
    if (done_cnt != 1 || done_pos != f - 1) begin
      tests_failed++;
      $display("FAIL done_pulse u%0d: count %0d at cycle %0d, expected 1 at %0d", i, done_cnt, done_pos, f - 1);
    end
    tests_run++;
    if (rdy_after !== 1'b1 || tx_after !== 1'b1 || dn_after !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_end u%0d: ready/tx/done = %b%b%b, expected 110", i, rdy_after, tx_after, dn_after);
    end
    tests_run++;
    if (busy_err != 0) begin
      tests_failed++;
      $display("FAIL busy_ready u%0d: %0d frame cycles not busy/not-ready, expected 0", i, busy_err);
    end
    foreach (edge_q[e]) begin
      tests_run++;
      if (edge_q[e] % c != 0) begin
        tests_failed++;
        $display("FAIL line_edge u%0d: edge at cycle %0d, expected multiple of %0d", i, edge_q[e], c);
      end
    end
  endtask

  task automatic test_spec_vectors();
    logic e_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic e_41 [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    run_frame(0, 8'hA5);
    for (int b = 0; b < 10; b++) begin
      tests_run++;
      if (obs[b] !== e_a5[b] || unst[b]) begin
        tests_failed++;
        $display("FAIL vec_8n1_a5 bit%0d: got %b, expected %b", b, obs[b], e_a5[b]);
      end
    end
    tests_run++;
    if (done_pos != 39 || done_cnt != 1 || rdy_after !== 1'b1) begin
      tests_failed++;
      $display("FAIL vec_8n1_timing: done at %0d x%0d ready_after %b, expected 39 x1 ready 1", done_pos, done_cnt, rdy_after);
    end
    for (int i = 1; i <= 2; i++) begin
      run_frame(i, 8'hA5);
      tests_run++;
      if (obs[9] !== logic'(i == 2) || done_pos != 43 || obs[10] !== 1'b1) begin
        tests_failed++;
        $display("FAIL vec_parity u%0d: parity %b done at %0d stop %b, expected %b 43 1", i, obs[9], done_pos, obs[10], logic'(i == 2));
      end
    end
    run_frame(3, 8'h41);
    for (int b = 0; b < 10; b++) begin
      tests_run++;
      if (obs[b] !== e_41[b] || unst[b]) begin
        tests_failed++;
        $display("FAIL vec_7n2_41 bit%0d: got %b, expected %b", b, obs[b], e_41[b]);
      end
    end
    tests_run++;
    if (done_cnt != 1 || done_pos != 39) begin
      tests_failed++;
      $display("FAIL vec_7n2_done: count %0d at %0d, expected 1 at 39", done_cnt, done_pos);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 4; n++)
        test_frame_format(i, 8'($urandom));
  endtask

  task automatic test_back_to_back();
    logic       cap [100];
    int         acc[$];
    logic [7:0] q [2] = '{8'h01, 8'hFF};
    int         sent = 0;
    int         busy_acc = 0;
    int         w = 0;
    int         bad;
    @(negedge clk);
    while (!rdy[0] && w < 50) begin @(negedge clk); w++; end
    td[0] = q[0]; tv[0] = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      cap[cyc] = txl[0];
      if (tv[0] && rdy[0]) begin
        acc.push_back(cyc);
        if (bsy[0] !== 1'b0) busy_acc++;
        sent++;
        @(posedge clk); #1;
        if (sent < 2) td[0] = q[sent];
        else tv[0] = 1'b0;
      end
      @(negedge clk);
    end
    tv[0] = 1'b0;
    tests_run++;
    if (acc.size() != 2 || busy_acc != 0) begin
      tests_failed++;
      $display("FAIL b2b_accepts: %0d accepts (%0d while busy), expected 2 (0)", acc.size(), busy_acc);
    end
    if (acc.size() == 2) begin
      tests_run++;
      if (acc[1] - acc[0] != 41 || cap[acc[0] + 41] !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_period: %0d cycles, gap line %b, expected 41 and 1", acc[1] - acc[0], cap[acc[0] + 41]);
      end
      for (int fr = 0; fr < 2; fr++)
        for (int b = 0; b < 10; b++) begin
          bad = 0;
          for (int s = 0; s < 4; s++)
            if (cap[acc[fr] + 1 + b * 4 + s] !== exp_bit(0, q[fr], b)) bad++;
          tests_run++;
          if (bad != 0) begin
            tests_failed++;
            $display("FAIL b2b_frame%0d bit%0d: %0d wrong samples, expected %b throughout", fr, b, bad, exp_bit(0, q[fr], b));
          end
        end
    end
  endtask

  task automatic test_reset_mid_frame();
    int w = 0;
    @(negedge clk);
    while (!rdy[0] && w < 50) begin @(negedge clk); w++; end
    td[0] = 8'hA5; tv[0] = 1'b1;
    @(posedge clk); #1;
    tv[0] = 1'b0;
    repeat (18) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (txl[0] !== 1'b1 || rdy[0] !== 1'b1 || dn[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort: tx/ready/done/busy = %b%b%b%b, expected 1100", txl[0], rdy[0], dn[0], bsy[0]);
    end
    reset = 1'b1;
    test_frame_format(0, 8'h3C);
  endtask

  task automatic test_long_baud();
    test_frame_format(4, 8'($urandom));
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin td[i] = 8'h00; tv[i] = 1'b0; end
    test_reset();
    test_spec_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    test_long_baud();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d of %0d tests failed so far", tests_failed, tests_run);
    $fatal(1);
  end

endmodule
